// File: rtl/fp_divsqrt_arbiter_pkg.sv
// Shared types and sizing helpers for the FP div/sqrt requester arbiter.
package fp_divsqrt_arbiter_pkg;

  // Default widths of the core-side APU port fields.
  localparam int FP_WIDTH         = 32;
  localparam int WAPUTAG          = 4;
  localparam int NDSFLAGS_DIVSQRT = 3;
  localparam int NUSFLAGS_DIVSQRT = 5;

  // Controller state: waiting for a winner, unit computing, result on offer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } divsqrt_arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int divsqrt_id_width(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

  localparam int DIVSQRT_ID_WIDTH = divsqrt_id_width(4);

endpackage

// File: rtl/fp_divsqrt_arbiter_if.sv
// Requester-side and unit-side signal bundle of the div/sqrt arbiter.
// slave: the arbiter's view; master: the surrounding interconnect and unit.
interface fp_divsqrt_arbiter_if
  import fp_divsqrt_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int TAG_WIDTH  = WAPUTAG,
  parameter int RND_WIDTH  = NDSFLAGS_DIVSQRT,
  parameter int STAT_WIDTH = NUSFLAGS_DIVSQRT,
  parameter int FP_WIDTH   = fp_divsqrt_arbiter_pkg::FP_WIDTH
);

  // Requester request/issue side
  logic [NREQ-1:0]           req_i;
  logic [NREQ-1:0]           gnt_o;
  logic [NREQ*FP_WIDTH-1:0]  opa_i;
  logic [NREQ*FP_WIDTH-1:0]  opb_i;
  logic [NREQ-1:0]           sqrt_sel_i;
  logic [NREQ*RND_WIDTH-1:0] rnd_i;
  logic [NREQ*TAG_WIDTH-1:0] tag_i;

  // Requester response side
  logic [NREQ-1:0]           resp_valid_o;
  logic [NREQ-1:0]           resp_ready_i;
  logic [FP_WIDTH-1:0]       resp_res_o;
  logic [STAT_WIDTH-1:0]     resp_status_o;
  logic [TAG_WIDTH-1:0]      resp_tag_o;

  // Div/sqrt unit side
  logic                      unit_en_o;
  logic [FP_WIDTH-1:0]       unit_opa_o;
  logic [FP_WIDTH-1:0]       unit_opb_o;
  logic                      unit_sqrt_o;
  logic [RND_WIDTH-1:0]      unit_rnd_o;
  logic                      unit_ready_i;
  logic                      unit_valid_i;
  logic [FP_WIDTH-1:0]       unit_res_i;
  logic [STAT_WIDTH-1:0]     unit_status_i;

  modport slave (
    input  req_i, opa_i, opb_i, sqrt_sel_i, rnd_i, tag_i, resp_ready_i,
           unit_ready_i, unit_valid_i, unit_res_i, unit_status_i,
    output gnt_o, resp_valid_o, resp_res_o, resp_status_o, resp_tag_o,
           unit_en_o, unit_opa_o, unit_opb_o, unit_sqrt_o, unit_rnd_o
  );

  modport master (
    output req_i, opa_i, opb_i, sqrt_sel_i, rnd_i, tag_i, resp_ready_i,
           unit_ready_i, unit_valid_i, unit_res_i, unit_status_i,
    input  gnt_o, resp_valid_o, resp_res_o, resp_status_o, resp_tag_o,
           unit_en_o, unit_opa_o, unit_opb_o, unit_sqrt_o, unit_rnd_o
  );

endinterface

// File: rtl/fp_divsqrt_arbiter_rr_arbiter_onehot.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping at NREQ-1 -> 0. Reusable by any shared-unit controller.
module rr_arbiter_onehot #(
  parameter int NREQ     = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NREQ-1:0]     req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NREQ-1:0]     gnt,
  output logic [ID_WIDTH-1:0] id
);

  localparam logic [NREQ-1:0]   ONE      = 1;
  localparam logic [ID_WIDTH:0] NREQ_EXT = (ID_WIDTH+1)'(NREQ);

  logic [2*NREQ-1:0]   req_rot;
  logic [ID_WIDTH-1:0] offset;
  logic [ID_WIDTH:0]   sum;
  logic                found;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then
  // map the offset back to an absolute requester index.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    req_rot = {req, req} >> rr_ptr;
    found   = 1'b0;
    offset  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        offset = ID_WIDTH'(i);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= NREQ_EXT) sum = sum - NREQ_EXT;
    id  = found ? sum[ID_WIDTH-1:0] : '0;
    gnt = found ? (ONE << id) : '0;
  end

endmodule

// File: rtl/fp_divsqrt_arbiter.sv
// Shares one iterative FP div/sqrt unit between NREQ requesters with
// round-robin arbitration and a single operation in flight. The winner's ID
// and tag are captured at issue and the unit's result is returned to that
// requester through a valid/ready handshake.
module fp_divsqrt_arbiter
  import fp_divsqrt_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int TAG_WIDTH  = WAPUTAG,
  parameter int RND_WIDTH  = NDSFLAGS_DIVSQRT,
  parameter int STAT_WIDTH = NUSFLAGS_DIVSQRT,
  parameter int FP_WIDTH   = fp_divsqrt_arbiter_pkg::FP_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fp_divsqrt_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic                 err_spurious_o
);

  localparam int ID_WIDTH = divsqrt_id_width(NREQ);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  localparam logic [NREQ-1:0]     ONE      = 1;
  localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NREQ-1);

  logic [1:0]            state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [FP_WIDTH-1:0]   res_q;
  logic [STAT_WIDTH-1:0] status_q;
  logic                  err_q;

  logic [NREQ-1:0]       req_eff;
  logic [NREQ-1:0]       gnt;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  issue;
  logic                  in_resp;
  logic                  accept;

  logic [FP_WIDTH-1:0]   mux_opa;
  logic [FP_WIDTH-1:0]   mux_opb;
  logic                  mux_sqrt;
  logic [RND_WIDTH-1:0]  mux_rnd;
  logic [TAG_WIDTH-1:0]  mux_tag;

  // Requests are only visible to the arbiter when a new op can start; reset
  // is folded in so nothing is granted while it is held.
  assign req_eff = (!rst_i && state_q == ST_IDLE && bus.unit_ready_i) ? bus.req_i : '0;

  rr_arbiter_onehot #(
    .NREQ     (NREQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req    (req_eff),
    .rr_ptr (rr_ptr_q),
    .gnt    (gnt),
    .id     (win_id)
  );

  assign issue    = |gnt;
  assign next_ptr = (win_id == LAST_ID) ? '0 : win_id + ID_WIDTH'(1);

  // One-hot operand mux: passes the winner's fields through in the grant
  // cycle and drives zeros when nobody is granted.
  always_comb begin
    mux_opa  = '0;
    mux_opb  = '0;
    mux_sqrt = 1'b0;
    mux_rnd  = '0;
    mux_tag  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mux_opa  |= bus.opa_i[i*FP_WIDTH +: FP_WIDTH];
        mux_opb  |= bus.opb_i[i*FP_WIDTH +: FP_WIDTH];
        mux_sqrt |= bus.sqrt_sel_i[i];
        mux_rnd  |= bus.rnd_i[i*RND_WIDTH +: RND_WIDTH];
        mux_tag  |= bus.tag_i[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.unit_en_o   = issue;
  assign bus.unit_opa_o  = mux_opa;
  assign bus.unit_opb_o  = mux_opb;
  assign bus.unit_sqrt_o = mux_sqrt;
  assign bus.unit_rnd_o  = mux_rnd;

  // Response side: only the issuing requester sees valid, only its ready
  // completes the transfer; the shared buses read zero outside RESP.
  assign in_resp = !rst_i && state_q == ST_RESP;
  assign accept  = in_resp && bus.resp_ready_i[id_q];

  assign bus.resp_valid_o  = in_resp ? (ONE << id_q) : '0;
  assign bus.resp_res_o    = in_resp ? res_q    : '0;
  assign bus.resp_status_o = in_resp ? status_q : '0;
  assign bus.resp_tag_o    = in_resp ? tag_q    : '0;

  assign busy_o         = !rst_i && state_q != ST_IDLE;
  assign err_spurious_o = !rst_i && err_q;

  // Issue/compute/respond FSM with the ID, tag and result holding registers;
  // a reset drops any operation in flight.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // here samples the pre-edge values and simulation matches the hardware.
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      tag_q    <= '0;
      res_q    <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (bus.unit_valid_i && state_q != ST_BUSY) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            id_q     <= win_id;
            tag_q    <= mux_tag;
            rr_ptr_q <= next_ptr;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.unit_valid_i) begin
            res_q    <= bus.unit_res_i;
            status_q <= bus.unit_status_i;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (accept) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
